// File: rtl/alu_rsv_station_pkg.sv
// Shared types for the ALU reservation station: ALU op codes and the entry layout.
// Tags are stored at a fixed maximum width so the struct can live in a package.
package alu_rsv_station_pkg;

  localparam int RSV_TAG_W = 16;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SLL = 5'd1,
    ALU_SRA = 5'd2,
    ALU_SUB = 5'd3,
    ALU_XOR = 5'd4,
    ALU_SRL = 5'd5,
    ALU_OR  = 5'd6,
    ALU_AND = 5'd7
  } alu_op_e;

  typedef struct packed {
    logic                 valid;
    alu_op_e              aluop;
    logic                 rs1_rdy;
    logic [RSV_TAG_W-1:0] rs1_tag;
    logic [31:0]          rs1_val;
    logic                 rs2_rdy;
    logic [RSV_TAG_W-1:0] rs2_tag;
    logic [31:0]          rs2_val;
    logic [RSV_TAG_W-1:0] rd_tag;
  } rsv_entry_t;

  // Capture a CDB broadcast into any operand still waiting on that tag.
  function automatic rsv_entry_t rsv_snoop(rsv_entry_t e, logic cdb_v,
                                           logic [RSV_TAG_W-1:0] tag, logic [31:0] value);
    rsv_entry_t r;
    r = e;
    if (cdb_v && !e.rs1_rdy && (e.rs1_tag == tag)) begin
      r.rs1_rdy = 1'b1;
      r.rs1_val = value;
    end
    if (cdb_v && !e.rs2_rdy && (e.rs2_tag == tag)) begin
      r.rs2_rdy = 1'b1;
      r.rs2_val = value;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rsv_station_select.sv
// Lowest-index picker: one-hot grant of the least significant request bit.
module alu_rsv_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         found_o
);

  // Two's-complement isolate-lowest-set-bit trick.
  assign gnt_o   = req_i & (~req_i + N'(1));
  assign found_o = |req_i;

endmodule

// File: rtl/alu_rsv_station.sv
// ALU reservation station: buffers micro-ops until operands arrive, issues via valid/ready.
// Optional ALU_RSV_WAKEUP_BYPASS_EN lets select see this cycle's CDB broadcast directly.
module alu_rsv_station
  import alu_rsv_station_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [4:0]       dispatch_aluop,
  input  logic             dispatch_rs1_rdy,
  input  logic [TAG_W-1:0] dispatch_rs1_tag,
  input  logic [31:0]      dispatch_rs1_val,
  input  logic             dispatch_rs2_rdy,
  input  logic [TAG_W-1:0] dispatch_rs2_tag,
  input  logic [31:0]      dispatch_rs2_val,
  input  logic [TAG_W-1:0] dispatch_rd_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [4:0]       issue_aluop,
  output logic [31:0]      issue_a,
  output logic [31:0]      issue_b,
  output logic [TAG_W-1:0] issue_rd_tag
);

  rsv_entry_t ent_q    [DEPTH];
  rsv_entry_t ent_d    [DEPTH];
  rsv_entry_t ent_wake [DEPTH];
  rsv_entry_t ent_sel  [DEPTH];
  rsv_entry_t disp_ent;
  rsv_entry_t cand;

  logic [DEPTH-1:0]     valid_vec, ready_vec, free_gnt, sel_gnt;
  logic                 free_found, sel_found, disp_fire, issue_load;
  logic [RSV_TAG_W-1:0] cdb_tag_x;
  logic                 unused_cand;

  logic                 issue_valid_q;
  logic [4:0]           issue_aluop_q;
  logic [31:0]          issue_a_q, issue_b_q;
  logic [TAG_W-1:0]     issue_rd_tag_q;

  assign cdb_tag_x = RSV_TAG_W'(cdb_tag);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign ent_wake[gi] = rsv_snoop(ent_q[gi], cdb_valid, cdb_tag_x, cdb_value);
`ifdef ALU_RSV_WAKEUP_BYPASS_EN
    assign ent_sel[gi] = ent_wake[gi];
`else
    assign ent_sel[gi] = ent_q[gi];
`endif
    assign valid_vec[gi] = ent_q[gi].valid;
    assign ready_vec[gi] = ent_sel[gi].valid & ent_sel[gi].rs1_rdy & ent_sel[gi].rs2_rdy;
  end

  alu_rsv_select #(.N(DEPTH)) u_free_pick (
    .req_i   (~valid_vec),
    .gnt_o   (free_gnt),
    .found_o (free_found)
  );

  alu_rsv_select #(.N(DEPTH)) u_issue_pick (
    .req_i   (ready_vec),
    .gnt_o   (sel_gnt),
    .found_o (sel_found)
  );

  // Free slots come from registered valid bits only, so a slot freed by issue is reused next cycle.
  assign dispatch_ready = free_found;
  assign disp_fire      = dispatch_valid & free_found & ~flush;
  assign issue_load     = ~issue_valid_q | issue_ready;

  always_comb begin
    disp_ent         = '0;
    disp_ent.valid   = 1'b1;
    disp_ent.aluop   = alu_op_e'(dispatch_aluop);
    disp_ent.rs1_rdy = dispatch_rs1_rdy;
    disp_ent.rs1_tag = RSV_TAG_W'(dispatch_rs1_tag);
    disp_ent.rs1_val = dispatch_rs1_val;
    disp_ent.rs2_rdy = dispatch_rs2_rdy;
    disp_ent.rs2_tag = RSV_TAG_W'(dispatch_rs2_tag);
    disp_ent.rs2_val = dispatch_rs2_val;
    disp_ent.rd_tag  = RSV_TAG_W'(dispatch_rd_tag);
    disp_ent         = rsv_snoop(disp_ent, cdb_valid, cdb_tag_x, cdb_value);
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_gnt[i]) cand = ent_sel[i];
    end
  end

  assign unused_cand = ^cand;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_wake[i];
      if (flush) begin
        ent_d[i].valid = 1'b0;
      end else if (issue_load && sel_gnt[i]) begin
        ent_d[i].valid = 1'b0;
      end else if (disp_fire && free_gnt[i]) begin
        ent_d[i] = disp_ent;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_q  <= 1'b0;
      issue_aluop_q  <= '0;
      issue_a_q      <= '0;
      issue_b_q      <= '0;
      issue_rd_tag_q <= '0;
    end else if (flush) begin
      issue_valid_q  <= 1'b0;
      issue_aluop_q  <= '0;
      issue_a_q      <= '0;
      issue_b_q      <= '0;
      issue_rd_tag_q <= '0;
    end else if (issue_load) begin
      issue_valid_q <= sel_found;
      if (sel_found) begin
        issue_aluop_q  <= cand.aluop;
        issue_a_q      <= cand.rs1_val;
        issue_b_q      <= cand.rs2_val;
        issue_rd_tag_q <= TAG_W'(cand.rd_tag);
      end
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_aluop  = issue_aluop_q;
  assign issue_a      = issue_a_q;
  assign issue_b      = issue_b_q;
  assign issue_rd_tag = issue_rd_tag_q;

endmodule

// File: tb/tb_alu_rsv_station.sv
// Bench for alu_rsv_station: directed scenarios, then random traffic against a scoreboard.
`timescale 1ns/1ps
module tb_alu_rsv_station;
  import alu_rsv_station_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int NRND  = 2000;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic             dispatch_valid, dispatch_ready;
  logic [4:0]       dispatch_aluop;
  logic             dispatch_rs1_rdy, dispatch_rs2_rdy;
  logic [TAG_W-1:0] dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rd_tag;
  logic [31:0]      dispatch_rs1_val, dispatch_rs2_val;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             issue_valid, issue_ready;
  logic [4:0]       issue_aluop;
  logic [31:0]      issue_a, issue_b;
  logic [TAG_W-1:0] issue_rd_tag;

  always #5 clk = ~clk;

  alu_rsv_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_aluop(dispatch_aluop),
    .dispatch_rs1_rdy(dispatch_rs1_rdy), .dispatch_rs1_tag(dispatch_rs1_tag),
    .dispatch_rs1_val(dispatch_rs1_val),
    .dispatch_rs2_rdy(dispatch_rs2_rdy), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs2_val(dispatch_rs2_val),
    .dispatch_rd_tag(dispatch_rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_aluop(issue_aluop), .issue_a(issue_a), .issue_b(issue_b),
    .issue_rd_tag(issue_rd_tag)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic [4:0] op,
                            input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] v2,
                            input logic [5:0] rd);
    dispatch_valid   = 1'b1;
    dispatch_aluop   = op;
    dispatch_rs1_rdy = r1; dispatch_rs1_tag = t1; dispatch_rs1_val = v1;
    dispatch_rs2_rdy = r2; dispatch_rs2_tag = t2; dispatch_rs2_val = v2;
    dispatch_rd_tag  = rd;
  endtask

  task automatic bcast(input logic [5:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
  endtask

  // Scoreboard for random traffic, keyed by destination tag.
  logic        exp_live [64];
  logic [4:0]  exp_op   [64];
  logic [31:0] exp_a    [64];
  logic [31:0] exp_b    [64];
  int          pend_tag [$];
  logic [31:0] pend_val [$];

  function automatic bit tag_pending(input int t);
    foreach (pend_tag[k]) if (pend_tag[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted, retired, station, src_ctr, rd_ctr, j, ridx;
    bit prev_stall, r1, r2, ok_done;
    logic [31:0] pv_a, pv_b, ea, eb, v1, v2;
    logic [4:0]  pv_op, op;
    logic [5:0]  pv_rd, t1, t2;

    rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    dispatch_valid = 1'b0; dispatch_aluop = '0;
    dispatch_rs1_rdy = 1'b0; dispatch_rs1_tag = '0; dispatch_rs1_val = '0;
    dispatch_rs2_rdy = 1'b0; dispatch_rs2_tag = '0; dispatch_rs2_val = '0;
    dispatch_rd_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    tick(); tick();
    check_eq("rst_issue_valid", issue_valid, 0);
    check_eq("rst_dispatch_ready", dispatch_ready, 1);
    check_eq("rst_issue_a", issue_a, 0);
    check_eq("rst_issue_rd", issue_rd_tag, 0);
    rst = 1'b0;
    tick();

    // Ready dispatch: lands in station, issues on the following edge.
    issue_ready = 1'b1;
    drive_disp(ALU_ADD, 1, 0, 5, 1, 0, 7, 6'd1);
    tick(); dispatch_valid = 1'b0;
    check_eq("t1_in_station", issue_valid, 0);
    tick();
    check_eq("t1_valid", issue_valid, 1);
    check_eq("t1_a", issue_a, 5);
    check_eq("t1_b", issue_b, 7);
    check_eq("t1_op", issue_aluop, ALU_ADD);
    check_eq("t1_rd", issue_rd_tag, 1);
    tick();
    check_eq("t1_drained", issue_valid, 0);
    check_eq("t1_dready", dispatch_ready, 1);

    // CDB wakeup of rs1.
    drive_disp(ALU_SUB, 0, 3, 32'h0, 1, 0, 1, 6'd2);
    tick(); dispatch_valid = 1'b0;
    check_eq("t2_waiting", issue_valid, 0);
    bcast(3, 10);
    tick(); cdb_valid = 1'b0;
`ifndef ALU_RSV_WAKEUP_BYPASS_EN
    check_eq("t2_not_yet", issue_valid, 0);
    tick();
`endif
    check_eq("t2_valid", issue_valid, 1);
    check_eq("t2_a", issue_a, 10);
    check_eq("t2_b", issue_b, 1);
    check_eq("t2_op", issue_aluop, ALU_SUB);
    tick();

    // Same-cycle capture at dispatch.
    drive_disp(ALU_XOR, 1, 0, 2, 0, 9, 32'h0, 6'd3);
    bcast(9, 32'hDEAD);
    tick(); dispatch_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    check_eq("t3_valid", issue_valid, 1);
    check_eq("t3_a", issue_a, 2);
    check_eq("t3_b", issue_b, 32'hDEAD);
    tick();

    // A broadcast on a ready operand's tag is ignored.
    drive_disp(ALU_OR, 1, 12, 4, 1, 12, 8, 6'd4);
    bcast(12, 99);
    tick(); dispatch_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    check_eq("t3b_a", issue_a, 4);
    check_eq("t3b_b", issue_b, 8);
    tick();

    // Full and stall: one op in the issue register, four queued, fixed-priority drain.
    issue_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_disp(ALU_ADD, 1, 0, k * 10 + 1, 1, 0, k, 6'(8 + k));
      tick();
      check_eq($sformatf("t4_dready_%0d", k), dispatch_ready, (k < 4) ? 1 : 0);
      if (k > 0) check_eq($sformatf("t4_hold_a_%0d", k), issue_a, 1);
    end
    dispatch_valid = 1'b0;
    tick();
    check_eq("t4_stall_dready", dispatch_ready, 0);
    check_eq("t4_stall_rd", issue_rd_tag, 8);
    issue_ready = 1'b1;
    tick();
    check_eq("t4_release_dready", dispatch_ready, 1);
    check_eq("t4_next_a", issue_a, 21);
    tick(); check_eq("t4_drain1_a", issue_a, 11);
    tick(); check_eq("t4_drain2_a", issue_a, 31);
    tick(); check_eq("t4_drain3_a", issue_a, 41);
    tick(); check_eq("t4_empty", issue_valid, 0);

    // Flush wins over a concurrent dispatch.
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_disp(ALU_AND, 1, 0, k, 1, 0, k, 6'(16 + k));
      tick();
    end
    check_eq("t5_pre_valid", issue_valid, 1);
    flush = 1'b1;
    drive_disp(ALU_AND, 1, 0, 77, 1, 0, 77, 6'd30);
    tick(); flush = 1'b0; dispatch_valid = 1'b0;
    check_eq("t5_flush_valid", issue_valid, 0);
    check_eq("t5_flush_dready", dispatch_ready, 1);
    issue_ready = 1'b1;
    tick(); tick();
    check_eq("t5_dropped", issue_valid, 0);

    // Asynchronous reset mid-cycle.
    drive_disp(ALU_SLL, 1, 0, 3, 1, 0, 4, 6'd5);
    issue_ready = 1'b0;
    tick(); dispatch_valid = 1'b0;
    tick();
    check_eq("t6_pre_valid", issue_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", issue_valid, 0);
    check_eq("t6_rst_a", issue_a, 0);
    check_eq("t6_rst_b", issue_b, 0);
    check_eq("t6_rst_op", issue_aluop, 0);
    check_eq("t6_rst_rd", issue_rd_tag, 0);
    check_eq("t6_rst_dready", dispatch_ready, 1);
    #1 rst = 1'b0;
    tick();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 64; i++) exp_live[i] = 1'b0;
    accepted = 0; retired = 0; src_ctr = 0; rd_ctr = 0;
    prev_stall = 1'b0; ok_done = 1'b0;
    pv_a = '0; pv_b = '0; pv_op = '0; pv_rd = '0;
    for (int cyc = 0; cyc < NRND + 400; cyc++) begin
      if (cyc >= NRND && pend_tag.size() == 0 && accepted == retired) begin
        ok_done = 1'b1;
        break;
      end
      station = accepted - retired - (issue_valid ? 1 : 0);
      check_eq("rnd_dready", dispatch_ready, (station < DEPTH) ? 1 : 0);
      if (prev_stall) begin
        check_eq("rnd_hold_valid", issue_valid, 1);
        check_eq("rnd_hold_a", issue_a, pv_a);
        check_eq("rnd_hold_b", issue_b, pv_b);
        check_eq("rnd_hold_op", issue_aluop, pv_op);
        check_eq("rnd_hold_rd", issue_rd_tag, pv_rd);
      end

      issue_ready = (cyc >= NRND) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (issue_valid && issue_ready) begin
        ridx = int'(issue_rd_tag);
        check_eq("rnd_live", exp_live[ridx], 1);
        check_eq("rnd_op", issue_aluop, exp_op[ridx]);
        check_eq("rnd_a", issue_a, exp_a[ridx]);
        check_eq("rnd_b", issue_b, exp_b[ridx]);
        exp_live[ridx] = 1'b0;
        retired++;
      end
      prev_stall = issue_valid && !issue_ready;
      pv_a = issue_a; pv_b = issue_b; pv_op = issue_aluop; pv_rd = issue_rd_tag;

      dispatch_valid = 1'b0;
      if (cyc < NRND && $urandom_range(0, 1) == 1) begin
        op = 5'($urandom_range(0, 7));
        r1 = (pend_tag.size() >= 14 || tag_pending(src_ctr)) ? 1'b1 : 1'($urandom_range(0, 1));
        if (r1) begin t1 = 6'($urandom_range(0, 63)); ea = $urandom; v1 = ea; end
        else begin t1 = 6'(src_ctr); src_ctr = (src_ctr + 1) % 48; ea = $urandom; v1 = $urandom; end
        r2 = (pend_tag.size() >= 14 || tag_pending(src_ctr)) ? 1'b1 : 1'($urandom_range(0, 1));
        if (r2) begin t2 = 6'($urandom_range(0, 63)); eb = $urandom; v2 = eb; end
        else begin t2 = 6'(src_ctr); src_ctr = (src_ctr + 1) % 48; eb = $urandom; v2 = $urandom; end
        drive_disp(op, r1, t1, v1, r2, t2, v2, 6'(rd_ctr));
        if (dispatch_ready) begin
          exp_live[rd_ctr] = 1'b1; exp_op[rd_ctr] = op;
          exp_a[rd_ctr] = ea; exp_b[rd_ctr] = eb;
          if (!r1) begin pend_tag.push_back(int'(t1)); pend_val.push_back(ea); end
          if (!r2) begin pend_tag.push_back(int'(t2)); pend_val.push_back(eb); end
          accepted++;
          rd_ctr = (rd_ctr + 1) % 64;
        end
      end

      cdb_valid = 1'b0;
      if (pend_tag.size() > 0 && $urandom_range(0, 1) == 1) begin
        j = ($urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(0, pend_tag.size() - 1));
        bcast(6'(pend_tag[j]), pend_val[j]);
        pend_tag.delete(j); pend_val.delete(j);
      end else if ($urandom_range(0, 7) == 0) begin
        bcast(6'($urandom_range(48, 63)), $urandom);
      end
      tick();
    end
    dispatch_valid = 1'b0; cdb_valid = 1'b0;
    check_eq("rnd_drained", ok_done, 1);
    check_eq("rnd_outstanding", accepted - retired, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
